ahb_arbiter: RTL

Bus arbiter for the 3-master / 8-slave AHB interconnect. Samples master bus requests and lock requests and tracks burst boundaries, locked sequences and SPLIT responses. Drives HGRANT to the masters, and HMASTER / HMASTER_del to the interconnect address/control and write-data multiplexers. Round-robin fairness, with a default master parked on the bus when no one requests.

---
 rtl/ahb_arbiter_pkg.sv | 30 +++
 rtl/ahb_arbiter_if.sv | 26 ++
 rtl/ahb_rr_pick.sv | 24 ++
 rtl/ahb_arbiter.sv | 103 ++++++++++
 4 files changed

// File: rtl/ahb_arbiter_pkg.sv
// ahb_arbiter_pkg: AHB transfer/burst/response encodings, arbiter state type and burst-length helpers
package ahb_arbiter_pkg;
  localparam int W_TRANS = 2;
  localparam int W_BURST = 3;
  localparam int W_RESP = 2;
  localparam logic [W_TRANS-1:0] TR_IDLE = 2'd0;
  localparam logic [W_TRANS-1:0] TR_BUSY = 2'd1;
  localparam logic [W_TRANS-1:0] TR_NONSEQ = 2'd2;
  localparam logic [W_TRANS-1:0] TR_SEQ = 2'd3;
  localparam logic [W_BURST-1:0] BU_SINGLE = 3'd0;
  localparam logic [W_BURST-1:0] BU_INCR = 3'd1;
  localparam logic [W_BURST-1:0] BU_WRAP4 = 3'd2;
  localparam logic [W_BURST-1:0] BU_INCR4 = 3'd3;
  localparam logic [W_BURST-1:0] BU_WRAP8 = 3'd4;
  localparam logic [W_BURST-1:0] BU_INCR8 = 3'd5;
  localparam logic [W_BURST-1:0] BU_WRAP16 = 3'd6;
  localparam logic [W_BURST-1:0] BU_INCR16 = 3'd7;
  localparam logic [W_RESP-1:0] RS_OKAY = 2'd0;
  localparam logic [W_RESP-1:0] RS_ERROR = 2'd1;
  localparam logic [W_RESP-1:0] RS_RETRY = 2'd2;
  localparam logic [W_RESP-1:0] RS_SPLIT = 2'd3;
  typedef enum logic [1:0] {ST_ARB, ST_BURST, ST_LOCKED} arb_state_t;
  // HBURST[2:1] encodes the beat count class: 0 undefined, 1/2/3 -> 4/8/16 beats
  function automatic logic [3:0] burst_beats_m1(input logic [W_BURST-1:0] hburst);
    return hburst[2:1] == 2'd1 ? 4'd3 : hburst[2:1] == 2'd2 ? 4'd7 : hburst[2:1] == 2'd3 ? 4'd15 : 4'd0;
  endfunction
  function automatic logic burst_fixed(input logic [W_BURST-1:0] hburst);
    return hburst[2:1] != 2'd0;
  endfunction
endpackage

// File: rtl/ahb_arbiter_if.sv
// ahb_arbiter_if: request/response inputs and grant/owner outputs between the masters' bus and the arbiter
interface ahb_arbiter_if #(
  parameter int N_MASTER = 3,
  parameter int W_MASTER = 2
);
  import ahb_arbiter_pkg::*;
  logic [N_MASTER-1:0] HBUSREQ;
  logic [N_MASTER-1:0] HLOCK;
  logic [W_TRANS-1:0] HTRANS;
  logic [W_BURST-1:0] HBURST;
  logic HREADY;
  logic [W_RESP-1:0] HRESP;
  logic [N_MASTER-1:0] HSPLIT;
  logic [N_MASTER-1:0] HGRANT;
  logic [W_MASTER-1:0] HMASTER;
  logic [W_MASTER-1:0] HMASTER_del;
  logic HMASTLOCK;
  modport slave (
    input HBUSREQ, HLOCK, HTRANS, HBURST, HREADY, HRESP, HSPLIT,
    output HGRANT, HMASTER, HMASTER_del, HMASTLOCK
  );
  modport master (
    output HBUSREQ, HLOCK, HTRANS, HBURST, HREADY, HRESP, HSPLIT,
    input HGRANT, HMASTER, HMASTER_del, HMASTLOCK
  );
endinterface

// File: rtl/ahb_rr_pick.sv
// ahb_rr_pick: combinational round-robin picker, first eligible requester after i_ptr, one-hot result
module ahb_rr_pick #(
  parameter int N = 3,
  parameter int W = 2
) (
  input logic [N-1:0] i_req,
  input logic [W-1:0] i_ptr,
  output logic [N-1:0] o_gnt,
  output logic o_valid
);
  logic [W:0] w_sh;
  logic [2*N-1:0] w_dbl;
  logic [2*N-1:0] w_oh2;
  logic [N-1:0] w_rot;
  logic [N-1:0] w_oh;
  // rotate so that master ptr+1 sits at bit 0, isolate the lowest set bit, rotate back
  assign w_sh = {1'b0, i_ptr} + (W+1)'(1);
  assign w_dbl = {i_req, i_req} >> w_sh;
  assign w_rot = w_dbl[N-1:0];
  assign w_oh = w_rot & (~w_rot + N'(1));
  assign w_oh2 = {w_oh, w_oh} << w_sh;
  assign o_gnt = w_oh2[2*N-1:N];
  assign o_valid = |i_req;
endmodule

// File: rtl/ahb_arbiter.sv
// ahb_arbiter: round-robin AHB bus arbiter with burst/lock tracking and default-master parking.
// Define AHB_SPLIT_EN to enable the SPLIT mask; otherwise SPLIT behaves as RETRY and HSPLIT is ignored.
module ahb_arbiter
  import ahb_arbiter_pkg::*;
#(
  parameter int N_MASTER = 3,
  parameter int W_MASTER = 2,
  parameter int NUM_DEF_MASTER = 0
) (
  input logic HCLK,
  input logic HRESET,
  ahb_arbiter_if.slave bus
);
  localparam logic [N_MASTER-1:0] DEF_OH = N_MASTER'(1) << NUM_DEF_MASTER;
  arb_state_t r_state;
  arb_state_t w_nstate;
  logic [N_MASTER-1:0] r_grant;
  logic [N_MASTER-1:0] w_mask;
  logic [N_MASTER-1:0] w_elig;
  logic [N_MASTER-1:0] w_pick;
  logic [N_MASTER-1:0] w_rr;
  logic [W_MASTER-1:0] r_hmaster;
  logic [W_MASTER-1:0] r_hmaster_del;
  logic [W_MASTER-1:0] w_gidx;
  logic [3:0] r_cnt;
  logic r_mastlock;
  logic w_valid;
  logic w_lock;
  logic w_abort;
  logic w_idle;
  logic w_seq;
  logic w_nonseq;
  logic w_fixed;
  logic w_incr_hold;
  logic w_burst_end;
  always_comb begin
    w_gidx = '0;
    for (int i = 0; i < N_MASTER; i++)
      if (r_grant[i]) w_gidx = W_MASTER'(i);
  end
  assign w_elig = bus.HBUSREQ & ~w_mask;
  ahb_rr_pick #(.N(N_MASTER), .W(W_MASTER)) u_pick (
    .i_req(w_elig),
    .i_ptr(w_gidx),
    .o_gnt(w_pick),
    .o_valid(w_valid)
  );
  assign w_rr = w_valid ? w_pick : DEF_OH;
  assign w_idle = bus.HTRANS == TR_IDLE;
  assign w_seq = bus.HTRANS == TR_SEQ;
  assign w_nonseq = bus.HTRANS == TR_NONSEQ;
  assign w_fixed = burst_fixed(bus.HBURST);
  assign w_lock = bus.HLOCK[w_gidx];
  assign w_abort = bus.HREADY && bus.HRESP != RS_OKAY;
  // an undefined-length INCR keeps the bus while its owner still requests
  assign w_incr_hold = (w_nonseq || w_seq) && bus.HBURST == BU_INCR && bus.HBUSREQ[w_gidx];
  assign w_burst_end = bus.HREADY && (w_idle || (w_seq && r_cnt <= 4'd1) || (w_nonseq && !w_fixed));
  always_comb begin
    w_nstate = w_lock ? ST_LOCKED
             : w_abort ? ST_ARB
             : r_state == ST_ARB ? ((bus.HREADY && w_nonseq && w_fixed) ? ST_BURST : ST_ARB)
             : r_state == ST_BURST ? (w_burst_end ? ST_ARB : ST_BURST)
             : (w_seq ? ST_LOCKED : ST_ARB);
  end
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_state <= ST_ARB;
      r_grant <= DEF_OH;
      r_hmaster <= W_MASTER'(NUM_DEF_MASTER);
      r_hmaster_del <= W_MASTER'(NUM_DEF_MASTER);
      r_mastlock <= 1'b0;
      r_cnt <= '0;
    end else begin
      r_state <= w_nstate;
      r_grant <= (w_nstate == ST_ARB && !w_incr_hold) ? w_rr : r_grant;
      if (bus.HREADY) begin
        r_hmaster <= w_gidx;
        r_hmaster_del <= r_hmaster;
        r_mastlock <= w_lock;
        r_cnt <= (w_abort || w_idle) ? 4'd0
               : w_nonseq ? burst_beats_m1(bus.HBURST)
               : (w_seq && r_cnt != 4'd0) ? r_cnt - 4'd1 : r_cnt;
      end
    end
  end
`ifdef AHB_SPLIT_EN
  logic [N_MASTER-1:0] r_mask;
  // a release in the same cycle as a new split wins
  always_ff @(posedge HCLK) begin
    if (HRESET) r_mask <= '0;
    else r_mask <= (r_mask | ((bus.HREADY && bus.HRESP == RS_SPLIT) ? N_MASTER'(1) << r_hmaster_del : '0)) & ~bus.HSPLIT;
  end
  assign w_mask = r_mask;
`else
  logic w_unused;
  assign w_unused = ^bus.HSPLIT;
  assign w_mask = '0;
`endif
  assign bus.HGRANT = r_grant;
  assign bus.HMASTER = r_hmaster;
  assign bus.HMASTER_del = r_hmaster_del;
  assign bus.HMASTLOCK = r_mastlock;
endmodule
